cache_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of `direct_mapping_cache`. It accepts read/write requests from two requesters (port 0: fetch side, port 1: load/store side) and issues exactly one at a time to the cache. It waits for the cache's `response`, then returns read data and miss status to the granted requester. A watchdog aborts transactions the cache never answers.

---
 rtl/cache_arb_pkg.sv | 30 +++
 rtl/cache_arbiter_sat_counter.sv | 26 ++
 rtl/cache_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_cache_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the two-port cache arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cache_arb_pkg;

    localparam int DEF_WORD_SIZE = 32;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // A lone requester always wins; on contention the port that did not win
    // last time is chosen.
    function automatic logic pick_winner(input logic [1:0] valid, input logic last);
        if (&valid) begin
            return ~last;
        end
        if (valid[PORT_LSU]) begin
            return PORT_LSU;
        end
        return PORT_FETCH;
    endfunction

endpackage

// File: rtl/cache_arbiter_sat_counter.sv
// Saturating event counter used for arbiter hit/miss/timeout statistics.
// Latency: count reflects an inc one cycle after it is sampled.
// Backpressure: none; sticks at all-ones instead of wrapping.
// Ports: clk, reset (sync, active-high), inc (count one event), count (current value).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin two-port arbiter/sequencer issuing one transaction at a time to the cache.
// Latency: request sampled at edge n -> cache_valid cycle n+1 -> earliest ack cycle n+3.
// Backpressure: requesters hold req_valid until ack; a WAIT watchdog aborts after TIMEOUT cycles.
// Ports: req_* (two requesters, shared rdata/miss/err valid with ack), cache_* (single
// cache port), hit/miss/timeout_count statistics. Optional macro CACHE_ARB_STATS_EN builds
// the statistics counters; without it the count ports read 0.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int TIMEOUT   = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic [1:0]           req_wr,
    input  logic [WORD_SIZE-1:0] req_addr0,
    input  logic [WORD_SIZE-1:0] req_addr1,
    input  logic [WORD_SIZE-1:0] req_data0,
    input  logic [WORD_SIZE-1:0] req_data1,
    output logic [1:0]           req_ack,
    output logic [WORD_SIZE-1:0] req_rdata,
    output logic                 req_miss,
    output logic                 req_err,
    output logic                 cache_valid,
    output logic [WORD_SIZE-1:0] cache_addr,
    output logic [WORD_SIZE-1:0] cache_data,
    output logic                 cache_wr,
    input  logic                 cache_response,
    input  logic                 cache_is_missrate,
    input  logic [WORD_SIZE-1:0] cache_out,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] timeout_count
);

    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

    arb_state_t           state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 port_q, port_d;
    logic                 wr_q, wr_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [7:0]           wd_q, wd_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                 miss_q, miss_d;
    logic                 err_q, err_d;
    logic                 winner;
    logic                 wd_expired;

    assign winner     = pick_winner(req_valid, last_grant_q);
    assign wd_expired = (wd_q == WD_LIMIT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cache_response || wd_expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: latched request, watchdog and captured response
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= PORT_LSU;
            port_q       <= PORT_FETCH;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wd_q         <= '0;
            rdata_q      <= '0;
            miss_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wd_q         <= wd_d;
            rdata_q      <= rdata_d;
            miss_q       <= miss_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        port_d       = port_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wd_d         = wd_q;
        rdata_d      = rdata_q;
        miss_d       = miss_q;
        err_d        = err_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    port_d       = winner;
                    last_grant_d = winner;
                    wr_d         = req_wr[winner];
                    addr_d       = winner ? req_addr1 : req_addr0;
                    wdata_d      = winner ? req_data1 : req_data0;
                end
            end
            ISSUE: wd_d = '0;
            WAIT: begin
                // A response in the last watchdog cycle still counts as a response.
                if (cache_response) begin
                    rdata_d = wr_q ? '0 : cache_out;
                    miss_d  = cache_is_missrate;
                    err_d   = 1'b0;
                end else if (wd_expired) begin
                    rdata_d = '0;
                    miss_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        req_ack     = 2'b00;
        cache_valid = 1'b0;
        cache_wr    = 1'b0;
        cache_addr  = addr_q;
        cache_data  = wdata_q;
        req_rdata   = rdata_q;
        req_miss    = miss_q;
        req_err     = err_q;
        unique case (state_q)
            ISSUE: begin
                cache_valid = 1'b1;
                cache_wr    = wr_q;
            end
            WAIT:    cache_wr = wr_q;
            DONE:    req_ack[port_q] = 1'b1;
            default: ;
        endcase
    end

`ifdef CACHE_ARB_STATS_EN
    logic in_done;
    assign in_done = (state_q == DONE);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_done && !miss_q && !err_q),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_done && miss_q),
        .count (miss_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_done && err_q),
        .count (timeout_count)
    );
`else
    assign hit_count     = '0;
    assign miss_count    = '0;
    assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter against a transaction-level model.
// Latency: checks every cycle on the falling edge.
// Backpressure: requesters hold req_valid until ack; a scripted cache answers late or never.
module tb_cache_arbiter;

    localparam int W   = 32;
    localparam int TO  = 4;
    localparam int CW  = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid, req_wr;
    logic [W-1:0]  req_addr0, req_addr1, req_data0, req_data1;
    logic [1:0]    req_ack;
    logic [W-1:0]  req_rdata;
    logic          req_miss, req_err;
    logic          cache_valid, cache_wr;
    logic [W-1:0]  cache_addr, cache_data;
    logic          cache_response, cache_is_missrate;
    logic [W-1:0]  cache_out;
    logic [CW-1:0] hit_count, miss_count, timeout_count;

    always #5 clk = ~clk;

    cache_arbiter #(.WORD_SIZE(W), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_wr            (req_wr),
        .req_addr0         (req_addr0),
        .req_addr1         (req_addr1),
        .req_data0         (req_data0),
        .req_data1         (req_data1),
        .req_ack           (req_ack),
        .req_rdata         (req_rdata),
        .req_miss          (req_miss),
        .req_err           (req_err),
        .cache_valid       (cache_valid),
        .cache_addr        (cache_addr),
        .cache_data        (cache_data),
        .cache_wr          (cache_wr),
        .cache_response    (cache_response),
        .cache_is_missrate (cache_is_missrate),
        .cache_out         (cache_out),
        .hit_count         (hit_count),
        .miss_count        (miss_count),
        .timeout_count     (timeout_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Pending request of each requester (what it drives while req_valid is high)
    logic [W-1:0] p_addr [2];
    logic [W-1:0] p_data [2];
    logic         p_wr   [2];

    // Behavioural cache contents: written data and read fills
    logic [W-1:0] mem [logic [W-1:0]];

    // Transaction-level model state
    int       cyc;
    bit       m_idle, after_ack, busy, lg_m;
    logic [1:0] v_prev;
    int       issue_cyc, ack_due, resp_at, resp_d;
    bit       t_port, t_wr, t_miss;
    logic [W-1:0] t_addr, t_data, t_out;
    logic [W-1:0] e_rdata;
    bit       e_miss, e_err;
    int       hit_m, miss_m, to_m, pend_kind;
    int       resets_done;

    task automatic new_req(input int p);
        p_addr[p] = W'($urandom_range(0, 3) * 4);
        p_data[p] = $urandom;
        p_wr[p]   = ($urandom_range(0, 2) == 0);
        req_valid[p] = 1'b1;
    endtask

    task automatic drive_reqs();
        req_addr0 = p_addr[0];
        req_addr1 = p_addr[1];
        req_data0 = p_data[0];
        req_data1 = p_data[1];
        req_wr    = {p_wr[1], p_wr[0]};
    endtask

    task automatic check_stats();
`ifdef CACHE_ARB_STATS_EN
        check("hit_count", hit_count, hit_m);
        check("miss_count", miss_count, miss_m);
        check("timeout_count", timeout_count, to_m);
`else
        check("hit_count", hit_count, 0);
        check("miss_count", miss_count, 0);
        check("timeout_count", timeout_count, 0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cache_valid"}, cache_valid, 0);
        check({tag, "_cache_wr"}, cache_wr, 0);
        check({tag, "_cache_addr"}, cache_addr, 0);
        check({tag, "_cache_data"}, cache_data, 0);
        check({tag, "_ack"}, req_ack, 0);
        check({tag, "_rdata"}, req_rdata, 0);
        check({tag, "_miss"}, req_miss, 0);
        check({tag, "_err"}, req_err, 0);
        check({tag, "_hits"}, hit_count, 0);
        check({tag, "_misses"}, miss_count, 0);
        check({tag, "_timeouts"}, timeout_count, 0);
    endtask

    task automatic model_reset();
        m_idle    = 1'b1;
        after_ack = 1'b0;
        busy      = 1'b0;
        lg_m      = 1'b1;
        resp_at   = -1;
        ack_due   = -1;
        hit_m     = 0;
        miss_m    = 0;
        to_m      = 0;
        pend_kind = 0;
    endtask

    task automatic step();
        bit exp_issue, w, do_reset;
        logic [1:0] exp_ack;
        @(negedge clk);
        cyc++;

        // Counters reflect a completed transaction one cycle after its ack
        case (pend_kind)
            1: if (hit_m < CMAX) hit_m++;
            2: if (miss_m < CMAX) miss_m++;
            3: if (to_m < CMAX) to_m++;
            default: ;
        endcase
        pend_kind = 0;
        check_stats();

        // Issue: one cycle after an idle cycle in which some port requested
        exp_issue = m_idle && (v_prev != 2'b00);
        check("cache_valid", cache_valid, exp_issue);
        if (exp_issue) begin
            w    = (&v_prev) ? ~lg_m : v_prev[1];
            lg_m = w;
            check("issue_addr", cache_addr, p_addr[w]);
            check("issue_data", cache_data, p_data[w]);
            t_port    = w;
            t_wr      = p_wr[w];
            t_addr    = p_addr[w];
            t_data    = p_data[w];
            issue_cyc = cyc;
            busy      = 1'b1;
            m_idle    = 1'b0;
            t_miss    = !mem.exists(t_addr);
            t_out     = (!t_wr && !t_miss) ? mem[t_addr] : W'($urandom);
            // Delays up to TO+1 land inside WAIT; longer ones land in DONE/IDLE and must be ignored
            resp_d    = $urandom_range(1, TO + 3);
            resp_at   = cyc + resp_d;
            if (resp_d <= TO + 1) begin
                ack_due = cyc + resp_d + 1;
                e_err   = 1'b0;
                e_miss  = t_miss;
                e_rdata = t_wr ? '0 : t_out;
            end else begin
                ack_due = cyc + TO + 2;
                e_err   = 1'b1;
                e_miss  = 1'b0;
                e_rdata = '0;
            end
        end else if (after_ack) begin
            m_idle    = 1'b1;
            after_ack = 1'b0;
        end

        // Command held stable from issue until the ack cycle
        check("cache_wr", cache_wr, busy && (cyc < ack_due) && t_wr);
        if (busy && (cyc < ack_due)) begin
            check("hold_addr", cache_addr, t_addr);
        end

        exp_ack = (busy && (cyc == ack_due)) ? (2'b01 << t_port) : 2'b00;
        check("ack", req_ack, exp_ack);
        if (busy && (cyc == ack_due)) begin
            check("rdata", req_rdata, e_rdata);
            check("miss", req_miss, e_miss);
            check("err", req_err, e_err);
            pend_kind = e_err ? 3 : (e_miss ? 2 : 1);
            busy      = 1'b0;
            after_ack = 1'b1;
        end

        do_reset = (resets_done < 3) && (cyc >= 400 * (resets_done + 1)) &&
                   busy && (cyc > issue_cyc) && (cyc < ack_due);

        if (do_reset) begin
            // Reset in the middle of WAIT: held requests stay up
            resets_done++;
            reset          = 1'b1;
            cache_response = 1'b0;
            @(negedge clk);
            cyc++;
            check_all_zero("mid_reset");
            model_reset();
            reset  = 1'b0;
            v_prev = req_valid;
            return;
        end

        // Scripted cache
        cache_response = (cyc == resp_at);
        if (cyc == resp_at) begin
            cache_out         = t_out;
            cache_is_missrate = t_miss;
            if (resp_d <= TO + 1) begin
                if (t_wr) mem[t_addr] = t_data;
                else if (t_miss) mem[t_addr] = t_out;
            end
        end else begin
            cache_out         = W'($urandom);
            cache_is_missrate = $urandom_range(0, 1);
        end

        // Requesters: drop on ack, then maybe post a new request
        for (int p = 0; p < 2; p++) begin
            if (exp_ack[p]) req_valid[p] = 1'b0;
            if (!req_valid[p] && ($urandom_range(0, 3) != 0)) new_req(p);
        end
        drive_reqs();
        v_prev = req_valid;
    endtask

    initial begin
        reset             = 1'b1;
        req_valid         = 2'b00;
        cache_response    = 1'b0;
        cache_is_missrate = 1'b0;
        cache_out         = '0;
        for (int p = 0; p < 2; p++) begin
            p_addr[p] = '0;
            p_data[p] = '0;
            p_wr[p]   = 1'b0;
        end
        drive_reqs();
        cyc         = 0;
        resets_done = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Both ports requesting straight out of reset: port 0 must win first
        reset = 1'b0;
        new_req(0);
        new_req(1);
        drive_reqs();
        v_prev = req_valid;

        for (int i = 0; i < 3000; i++) begin
            step();
        end

        check("resets_exercised", resets_done, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
